// File: rtl/div_pkg.sv
// ----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the iterative integer divider.
//   WIDTH          : default operand width
//   DIV_CYCLES     : default iteration count, one quotient bit per cycle
//   DIV_ZERO_QUOT  : quotient returned for a divide by zero (all ones)
//   divState_t     : FSM state encoding (IDLE / BUSY / DONE)
// ----------------------------------------------------------------------------
package div_pkg;

    localparam int WIDTH      = 32;
    localparam int DIV_CYCLES = WIDTH;

    localparam logic [WIDTH-1:0] DIV_ZERO_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divState_t;

endpackage

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One restoring-division iteration, purely combinational.
//   remIn    : partial remainder (always < divisor)
//   quotIn   : remaining dividend bits shifted out at the top, quotient
//              bits collected at the bottom
//   divisor  : magnitude of the divisor (non-zero)
//   remOut   : next partial remainder
//   quotOut  : next {dividend, quotient} word with the new quotient bit in LSB
// ----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quotIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quotOut
);

    logic [WIDTH:0] remShift;
    logic [WIDTH:0] diff;
    logic           fits;

    // Shift {rem, quot} left by one: the dividend MSB enters the remainder.
    assign remShift = {remIn, quotIn[WIDTH-1]};
    assign diff     = remShift - {1'b0, divisor};

    // Because remIn < divisor, remShift <= 2*divisor-1, so a non-negative
    // difference always fits in WIDTH bits and the extra bit is a pure borrow.
    assign fits = ~diff[WIDTH];

    assign remOut  = fits ? diff[WIDTH-1:0] : remShift[WIDTH-1:0];
    assign quotOut = {quotIn[WIDTH-2:0], fits};

endmodule

// File: rtl/div_unit.sv
// ----------------------------------------------------------------------------
// div_unit
// Multi-cycle DIV/DIVU unit for the execute stage. Operands are converted to
// magnitudes, divided by a restoring divider one bit per cycle, and the
// quotient/remainder signs are applied when the result is written.
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   start      : E-stage holds a divide; held high while stalled
//   signed_div : 1 = signed DIV, 0 = DIVU (sampled with start)
//   annul      : cancels the operation in flight
//   a, b       : dividend, divisor
//   result     : {remainder, quotient}, held until the next completion
//   ready      : one-cycle pulse, result valid
//   stall_div  : pipeline stall request while the divide is outstanding
// ----------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH      = div_pkg::WIDTH,
    parameter int DIV_CYCLES = div_pkg::DIV_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic               annul,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall_div
);

    import div_pkg::*;

    localparam int                CNT_W      = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LAST_COUNT = CNT_W'(DIV_CYCLES - 1);
    localparam logic [WIDTH-1:0]  ZERO_QUOT  =
        (WIDTH == div_pkg::WIDTH) ? WIDTH'(DIV_ZERO_QUOT) : {WIDTH{1'b1}};

    divState_t          stateReg;
    divState_t          stateNext;
    logic [CNT_W-1:0]   countReg;
    logic [WIDTH-1:0]   remReg;
    logic [WIDTH-1:0]   quotReg;
    logic [WIDTH-1:0]   divisorReg;
    logic               quotNegReg;
    logic               remNegReg;
    logic [2*WIDTH-1:0] resultReg;

    logic               loadOp;
    logic               divZero;
    logic               stepEn;
    logic               finishOp;

    logic               signA;
    logic               signB;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [WIDTH-1:0]   stepRem;
    logic [WIDTH-1:0]   stepQuot;
    logic [WIDTH-1:0]   fixRem;
    logic [WIDTH-1:0]   fixQuot;

    // Operand magnitudes. The most negative value maps onto itself, which is
    // the correct unsigned magnitude, so no special case is needed.
    assign signA = signed_div & a[WIDTH-1];
    assign signB = signed_div & b[WIDTH-1];
    assign absA  = signA ? -a : a;
    assign absB  = signB ? -b : b;

    div_step #(
        .WIDTH   (WIDTH)
    ) stepInst (
        .remIn   (remReg),
        .quotIn  (quotReg),
        .divisor (divisorReg),
        .remOut  (stepRem),
        .quotOut (stepQuot)
    );

    // Sign correction applies to the values produced by the final step.
    assign fixQuot = quotNegReg ? -stepQuot : stepQuot;
    assign fixRem  = remNegReg  ? -stepRem  : stepRem;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        loadOp    = 1'b0;
        divZero   = 1'b0;
        stepEn    = 1'b0;
        finishOp  = 1'b0;
        case (stateReg)
            IDLE: begin
                if (start && !annul) begin
                    if (b == '0) begin
                        divZero   = 1'b1;
                        stateNext = DONE;
                    end else begin
                        loadOp    = 1'b1;
                        stateNext = BUSY;
                    end
                end
            end
            BUSY: begin
                if (annul) begin
                    stateNext = IDLE;
                end else begin
                    stepEn = 1'b1;
                    if (countReg == LAST_COUNT) begin
                        finishOp  = 1'b1;
                        stateNext = DONE;
                    end
                end
            end
            DONE: begin
                // start is ignored here; a held start re-issues from IDLE.
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            countReg   <= '0;
            remReg     <= '0;
            quotReg    <= '0;
            divisorReg <= '0;
            quotNegReg <= 1'b0;
            remNegReg  <= 1'b0;
            resultReg  <= '0;
        end else begin
            if (loadOp) begin
                countReg   <= '0;
                remReg     <= '0;
                quotReg    <= absA;
                divisorReg <= absB;
                quotNegReg <= signA ^ signB;
                remNegReg  <= signA;
            end
            if (stepEn) begin
                countReg <= countReg + 1'b1;
                remReg   <= stepRem;
                quotReg  <= stepQuot;
            end
            if (finishOp) begin
                resultReg <= {fixRem, fixQuot};
            end
            if (divZero) begin
                // Remainder is the raw dividend, without sign treatment.
                resultReg <= {a, ZERO_QUOT};
            end
        end
    end

    assign ready     = (stateReg == DONE);
    assign stall_div = start & ~ready & ~annul & ~rst;
    assign result    = resultReg;

endmodule

// File: tb/tb_div_unit.sv
// ----------------------------------------------------------------------------
// tb_div_unit
// Self-checking bench for div_unit: a vector table of divides applied one at
// a time, plus hand-written sequences for stall timing, back-to-back issue,
// annul and reset in flight. Each expected result and its completion cycle
// are queued when the operation is issued and checked when ready pulses.
// ----------------------------------------------------------------------------
module tb_div_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           signed_div;
    logic           annul;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] result;
    logic           ready;
    logic           stall_div;

    div_unit #(
        .WIDTH      (W),
        .DIV_CYCLES (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .a          (a),
        .b          (b),
        .result     (result),
        .ready      (ready),
        .stall_div  (stall_div)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] res;
        int             due;
    } exp_t;

    typedef struct {
        logic [W-1:0]   va;
        logic [W-1:0]   vb;
        bit             sgn;
        logic [2*W-1:0] res;
        int             lat;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[14];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard: every ready pulse must match the oldest queued expectation,
    // both in value and in the cycle it arrives.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (ready === 1'b1) begin
            txn++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: result %h at cycle %0d, none expected", result, cyc);
            end else begin
                e = sbq.pop_front();
                $display("txn %0d: result=%h cycle=%0d", txn, result, cyc);
                check("result", result, e.res);
                check("ready_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic pushExp(input logic [2*W-1:0] res, input int due);
        exp_t e;
        e.res = res;
        e.due = due;
        sbq.push_back(e);
    endtask

    // Waits on negedges for ready; leaves the caller at the ready negedge.
    task automatic waitReady(input int bound);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ready_timeout: no ready within %0d cycles, expected one", bound);
            sbq.delete();
        end
    endtask

    task automatic runOp(input logic [W-1:0] opA, input logic [W-1:0] opB, input bit sgn,
                         input logic [2*W-1:0] res, input int lat);
        @(posedge clk); #1;
        a          = opA;
        b          = opB;
        signed_div = sgn;
        start      = 1'b1;
        pushExp(res, cyc + lat);
        waitReady(lat + 5);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'd7,        32'd2,        1'b0, {32'h00000001, 32'h00000003}, 33};
        vecs[1]  = '{32'hFFFFFFF9, 32'd2,        1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33};
        vecs[2]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h00000000, 32'h80000000}, 33};
        vecs[3]  = '{32'd5,        32'd0,        1'b0, {32'h00000005, 32'hFFFFFFFF}, 1};
        vecs[4]  = '{32'd100,      32'd7,        1'b0, {32'h00000002, 32'h0000000E}, 33};
        vecs[5]  = '{32'hFFFFFFFF, 32'h10,       1'b0, {32'h0000000F, 32'h0FFFFFFF}, 33};
        vecs[6]  = '{32'd7,        32'hFFFFFFFE, 1'b1, {32'h00000001, 32'hFFFFFFFD}, 33};
        vecs[7]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, {32'hFFFFFFFF, 32'h00000003}, 33};
        vecs[8]  = '{32'hFFFFFFF9, 32'd2,        1'b0, {32'h00000001, 32'h7FFFFFFC}, 33};
        vecs[9]  = '{32'hFFFFFFFB, 32'd0,        1'b1, {32'hFFFFFFFB, 32'hFFFFFFFF}, 1};
        vecs[10] = '{32'd0,        32'd3,        1'b0, {32'h00000000, 32'h00000000}, 33};
        vecs[11] = '{32'h12345678, 32'h1000,     1'b0, {32'h00000678, 32'h00012345}, 33};
        vecs[12] = '{32'h80000000, 32'd1,        1'b1, {32'h00000000, 32'h80000000}, 33};
        vecs[13] = '{32'd3,        32'd5,        1'b0, {32'h00000003, 32'h00000000}, 33};

        rst        = 1'b1;
        start      = 1'b1;
        signed_div = 1'b0;
        annul      = 1'b0;
        a          = 32'd9;
        b          = 32'd3;

        // Reset state, with start high to show stall is masked by reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_result", result, 64'd0);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_stall", 64'(stall_div), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        rst   = 1'b0;

        // Table of single divides.
        for (int i = 0; i < 14; i++) begin
            runOp(vecs[i].va, vecs[i].vb, vecs[i].sgn, vecs[i].res, vecs[i].lat);
        end

        // Stall window for 7/2: high from T through T+32, low at T+33.
        @(posedge clk); #1;
        a = 32'd7; b = 32'd2; signed_div = 1'b0; start = 1'b1;
        pushExp({32'h00000001, 32'h00000003}, cyc + 33);
        for (int k = 0; k <= 33; k++) begin
            @(negedge clk);
            check($sformatf("stall_T+%0d", k), 64'(stall_div), (k <= 32) ? 64'd1 : 64'd0);
        end
        start = 1'b0;

        // Back-to-back: 100/7 then 0xFFFFFFFF/0x10, start never dropped.
        @(posedge clk); #1;
        a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
        pushExp({32'h00000002, 32'h0000000E}, cyc + 33);
        waitReady(40);
        a = 32'hFFFFFFFF; b = 32'h10;
        pushExp({32'h0000000F, 32'h0FFFFFFF}, cyc + 34);
        waitReady(40);
        start = 1'b0;

        // Annul at T+10 during BUSY; a new op issued at T+11 proves IDLE.
        @(posedge clk); #1;
        a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1;
        @(negedge clk);
        check("annul_stall", 64'(stall_div), 64'd0);
        @(posedge clk); #1;
        annul = 1'b0;
        a = 32'd3; b = 32'd5;
        pushExp({32'h00000003, 32'h00000000}, cyc + 33);
        repeat (10) @(negedge clk);
        check("annul_result_held", result, {32'h0000000F, 32'h0FFFFFFF});
        waitReady(40);
        start = 1'b0;

        // Reset pulsed at T+5 with start held; divide restarts after release.
        @(posedge clk); #1;
        a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_result", result, 64'd0);
        check("rst_mid_ready", 64'(ready), 64'd0);
        check("rst_mid_stall", 64'(stall_div), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        pushExp({32'h00000002, 32'h0000000E}, cyc + 33);
        waitReady(40);
        start = 1'b0;

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
